fact_game_ctrl: RTL and testbench
=================================

FACT_GAME_CTRL -- requirements
Module: fact_game_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter Q_TICKS, default 2, SHALL set the number of TICK pulses spent in QUESTION.
REQ-003 Parameter IN_TICKS, default 5, SHALL set the number of TICK pulses allowed in INPUT before timeout.
REQ-004 Parameter RES_TICKS, default 2, SHALL set the number of TICK pulses spent in GOOD, WRONG or OUCH.
REQ-005 Parameter N_ROUNDS, default 4, SHALL set the number of questions per game (range 1..7).
REQ-006 Port CLK, input, 1 bit, SHALL be the system clock; all state changes occur on the rising edge.
REQ-007 Port nRST, input, 1 bit, SHALL be the synchronous active-low reset.
REQ-008 Port START, input, 1 bit, SHALL be a one-cycle pulse that starts a game or returns from a final state.
REQ-009 Port BTN_SEL, input, 1 bit, SHALL be a one-cycle pulse that advances the factor choice.
REQ-010 Port BTN_OK, input, 1 bit, SHALL be a one-cycle pulse that submits the current choice.
REQ-011 Port TICK, input, 1 bit, SHALL be a one-cycle timebase enable pulse.
REQ-012 Port STATE, output, 4 bits, SHALL be the registered game state code that drives the 7-segment decoder.
REQ-013 Port QUE, output, 4 bits, SHALL be the registered question digit, in the range 2..9.
REQ-014 Port DIN, output, 4 bits, SHALL be the registered choice index, in the range 0..4.
REQ-015 Port SCORE, output, 3 bits, SHALL be the number of correct answers in the current game.

Function
REQ-016 The STATE codes SHALL be: READY=0010, QUESTION=0011, INPUT=0100, DRAW=0110, WRONG=0111, GOOD=1000, OUCH=1001, WIN=1010, LOSE=1011.
REQ-017 An 8-bit LFSR SHALL shift left every clock, including in READY: seed 0x01, input bit = b7^b5^b4^b3; it is never all-zero.
REQ-018 On entry to QUESTION, QUE SHALL load 2 + LFSR[2:0] (range 2..9) and hold that value until the next entry to QUESTION.
REQ-019 READY SHALL go to QUESTION on START; on that transition SCORE=0 and the round counter=0.
REQ-020 QUESTION SHALL go to INPUT after Q_TICKS TICK pulses, with DIN=0 and the tick timer cleared.
REQ-021 In INPUT, BTN_SEL SHALL increment DIN, wrapping 4 back to 0.
REQ-022 The choice mapping SHALL be DIN 1=2, 2=3, 3=5, 4=7; DIN 0 means no choice.
REQ-023 In INPUT, BTN_OK with DIN=0 SHALL be ignored.
REQ-024 In INPUT, BTN_OK with DIN≠0 SHALL go to GOOD (and increment SCORE) if the chosen prime divides QUE, otherwise to WRONG.
REQ-025 The divisibility check SHALL be a fixed lookup over QUE 2..9: 2|{2,4,6,8}, 3|{3,6,9}, 5|{5}, 7|{7}.
REQ-026 In INPUT, the IN_TICKS-th TICK without a valid BTN_OK SHALL go to OUCH.
REQ-027 If BTN_OK arrives in the same cycle as BTN_SEL, BTN_OK SHALL win and evaluate the pre-increment DIN.
REQ-028 If a valid BTN_OK arrives in the same cycle as the timeout TICK, BTN_OK SHALL win.
REQ-029 GOOD, WRONG and OUCH SHALL each hold for RES_TICKS TICK pulses, then increment the round counter.
REQ-030 After that increment, if the round count is below N_ROUNDS the block SHALL go to QUESTION; otherwise it SHALL go to the final verdict.
REQ-031 The final verdict SHALL be: SCORE ≥ N_ROUNDS-1 gives WIN; SCORE = N_ROUNDS-2 gives DRAW; otherwise LOSE.
REQ-032 WIN, DRAW and LOSE SHALL hold until START, then go to READY; SCORE holds its value until the next game starts.
REQ-033 START SHALL be ignored in every state except READY, WIN, DRAW and LOSE.
REQ-034 BTN_SEL and BTN_OK SHALL be ignored outside INPUT.
REQ-035 TICK SHALL be ignored in READY, WIN, DRAW and LOSE.
REQ-036 Any unused STATE encoding SHALL return to READY on the next clock.
REQ-037 DIN SHALL hold its last value outside INPUT and be cleared on entry to INPUT.
REQ-038 All outputs SHALL be registered, with one cycle of latency from an input pulse to its output change.

Reset
REQ-039 With nRST=0 at a clock edge, the block SHALL set STATE=0010, QUE=0, DIN=0, SCORE=0, round=0, timer=0 and LFSR=0x01.
REQ-040 Reset asserted mid-game SHALL abort immediately to those values, with no verdict state produced.

Verification
REQ-041 Reset then START: STATE=0011 one cycle later, with QUE in 2..9; after 2 TICKs STATE=0100 and DIN=0.
REQ-042 Selection wrap: 5 BTN_SEL pulses in INPUT SHALL step DIN 1,2,3,4,0; a BTN_OK at DIN=0 SHALL leave STATE=0100.
REQ-043 Correct answer: QUE=6 with DIN=2 and BTN_OK SHALL give STATE=1000 and SCORE=1.
REQ-044 Wrong answer: QUE=9 with DIN=1 and BTN_OK SHALL give STATE=0111 and leave SCORE unchanged.
REQ-045 Timeout: 5 TICKs in INPUT with no OK SHALL give STATE=1001.
REQ-046 A simultaneous BTN_OK and 5th TICK SHALL give GOOD or WRONG, not OUCH.
REQ-047 Full game: 4 correct answers SHALL give STATE=1010 and SCORE=4; 2 correct SHALL give 0110; 0 correct SHALL give 1011.
REQ-048 After any verdict, START SHALL give STATE=0010.
REQ-049 nRST pulsed while STATE=0100 SHALL give STATE=0010 and SCORE=0 on the next edge.

Source files
------------

// File: rtl/fact_game_ctrl.sv
// fact_game_ctrl -- controller for a "find a prime factor" quiz game.
//
// A question digit (2..9) is drawn from a free-running LFSR. The player
// steps through the prime choices 2/3/5/7 with BTN_SEL and submits with
// BTN_OK before the input window times out. After N_ROUNDS questions the
// block shows a WIN / DRAW / LOSE verdict until START is pressed again.
//
// Ports:
//   CLK     : system clock, all state changes on the rising edge
//   nRST    : synchronous active-low reset
//   START   : one-cycle pulse, starts a game / leaves a verdict state
//   BTN_SEL : one-cycle pulse, advances the choice index
//   BTN_OK  : one-cycle pulse, submits the current choice
//   TICK    : one-cycle timebase enable
//   STATE   : registered game state code for the 7-segment decoder
//   QUE     : registered question digit (2..9)
//   DIN     : registered choice index (0 = none, 1..4 = 2,3,5,7)
//   SCORE   : correct answers in the current game
module fact_game_ctrl #(
  parameter int Q_TICKS   = 2,
  parameter int IN_TICKS  = 5,
  parameter int RES_TICKS = 2,
  parameter int N_ROUNDS  = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       START,
  input  logic       BTN_SEL,
  input  logic       BTN_OK,
  input  logic       TICK,
  output logic [3:0] STATE,
  output logic [3:0] QUE,
  output logic [3:0] DIN,
  output logic [2:0] SCORE
);

  localparam logic [3:0] READY    = 4'b0010;
  localparam logic [3:0] QUESTION = 4'b0011;
  localparam logic [3:0] INPUT    = 4'b0100;
  localparam logic [3:0] DRAW     = 4'b0110;
  localparam logic [3:0] WRONG    = 4'b0111;
  localparam logic [3:0] GOOD     = 4'b1000;
  localparam logic [3:0] OUCH     = 4'b1001;
  localparam logic [3:0] WIN      = 4'b1010;
  localparam logic [3:0] LOSE     = 4'b1011;

  logic [7:0] lfsr;
  logic [7:0] timer;
  logic [2:0] round;

  logic       lfsr_fb;
  logic       ok_valid;
  logic       hit;
  logic       q_last;
  logic       in_last;
  logic       res_last;
  logic [2:0] round_inc;
  logic [3:0] new_que;
  logic [3:0] verdict;

  // Fixed divisibility table for question digits 2..9.
  function automatic logic divides(input logic [3:0] q, input logic [3:0] d);
    case (d)
      4'd1:    return (q == 4'd2) || (q == 4'd4) || (q == 4'd6) || (q == 4'd8);
      4'd2:    return (q == 4'd3) || (q == 4'd6) || (q == 4'd9);
      4'd3:    return (q == 4'd5);
      4'd4:    return (q == 4'd7);
      default: return 1'b0;
    endcase
  endfunction

  // Decode helpers shared by the state register below. The verdict uses the
  // current SCORE, which is already final when the last result state ends.
  always_comb begin
    lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    ok_valid  = BTN_OK && (DIN != 4'd0);
    hit       = divides(QUE, DIN);
    q_last    = (timer == 8'(Q_TICKS - 1));
    in_last   = (timer == 8'(IN_TICKS - 1));
    res_last  = (timer == 8'(RES_TICKS - 1));
    round_inc = round + 3'd1;
    new_que   = 4'd2 + {1'b0, lfsr[2:0]};
    if (int'(SCORE) >= N_ROUNDS - 1) begin
      verdict = WIN;
    end else if (int'(SCORE) == N_ROUNDS - 2) begin
      verdict = DRAW;
    end else begin
      verdict = LOSE;
    end
  end

  // Game state machine. The LFSR runs every cycle so the question drawn
  // depends on how long the player waits before pressing START. In INPUT a
  // valid BTN_OK takes priority over both BTN_SEL and the timeout tick.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      STATE <= READY;
      QUE   <= 4'd0;
      DIN   <= 4'd0;
      SCORE <= 3'd0;
      round <= 3'd0;
      timer <= 8'd0;
      lfsr  <= 8'h01;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
      case (STATE)
        READY: begin
          if (START) begin
            STATE <= QUESTION;
            QUE   <= new_que;
            SCORE <= 3'd0;
            round <= 3'd0;
            timer <= 8'd0;
          end
        end
        QUESTION: begin
          if (TICK) begin
            if (q_last) begin
              STATE <= INPUT;
              DIN   <= 4'd0;
              timer <= 8'd0;
            end else begin
              timer <= timer + 8'd1;
            end
          end
        end
        INPUT: begin
          if (ok_valid) begin
            STATE <= hit ? GOOD : WRONG;
            timer <= 8'd0;
            if (hit) begin
              SCORE <= SCORE + 3'd1;
            end
          end else begin
            if (BTN_SEL) begin
              DIN <= (DIN == 4'd4) ? 4'd0 : DIN + 4'd1;
            end
            if (TICK) begin
              if (in_last) begin
                STATE <= OUCH;
                timer <= 8'd0;
              end else begin
                timer <= timer + 8'd1;
              end
            end
          end
        end
        GOOD, WRONG, OUCH: begin
          if (TICK) begin
            if (res_last) begin
              timer <= 8'd0;
              round <= round_inc;
              if (int'(round_inc) < N_ROUNDS) begin
                STATE <= QUESTION;
                QUE   <= new_que;
              end else begin
                STATE <= verdict;
              end
            end else begin
              timer <= timer + 8'd1;
            end
          end
        end
        DRAW, WIN, LOSE: begin
          if (START) begin
            STATE <= READY;
          end
        end
        default: begin
          STATE <= READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fact_game_ctrl.sv
// tb_fact_game_ctrl -- directed self-checking bench for fact_game_ctrl.
//
// Inputs change on the falling edge and are held for exactly one rising
// edge; outputs are compared on the following falling edge. The question
// digit is predicted from a reference LFSR kept in the bench, which also
// lets the bench wait for a chosen question before pressing START.
module tb_fact_game_ctrl;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       START = 1'b0;
  logic       BTN_SEL = 1'b0;
  logic       BTN_OK = 1'b0;
  logic       TICK = 1'b0;
  logic [3:0] STATE;
  logic [3:0] QUE;
  logic [3:0] DIN;
  logic [2:0] SCORE;

  int         assert_count = 0;
  int         fail_count = 0;
  logic [7:0] ref_lfsr;
  logic [3:0] exp_que;
  logic [3:0] next_que;
  int         exp_score;
  int         exp_round;
  int         d;

  fact_game_ctrl dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .START   (START),
    .BTN_SEL (BTN_SEL),
    .BTN_OK  (BTN_OK),
    .TICK    (TICK),
    .STATE   (STATE),
    .QUE     (QUE),
    .DIN     (DIN),
    .SCORE   (SCORE)
  );

  always #5 CLK = ~CLK;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed 0x01, advancing every clock.
  always @(posedge CLK) begin
    if (!nRST) begin
      ref_lfsr <= 8'h01;
    end else begin
      ref_lfsr <= {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
    end
  end

  task automatic applyStimulus(input bit s, input bit sel, input bit ok, input bit tk);
    START   = s;
    BTN_SEL = sel;
    BTN_OK  = ok;
    TICK    = tk;
    @(negedge CLK);
    START   = 1'b0;
    BTN_SEL = 1'b0;
    BTN_OK  = 1'b0;
    TICK    = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Idle until the reference LFSR shows the wanted low bits, bounded.
  task automatic waitLow3(input logic [2:0] v);
    bit found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ref_lfsr[2:0] == v) begin
        found = 1'b1;
        break;
      end
      applyStimulus(0, 0, 0, 0);
    end
    if (!found) begin
      fail_count++;
      $display("[TB] FAIL wait_lfsr observed=%0d expected=%0d", ref_lfsr[2:0], v);
    end
  endtask

  // Choice index for a right or a wrong answer to question q.
  function automatic int pickDin(input int q, input bit correct);
    if (correct) begin
      if (q % 2 == 0) return 1;
      if (q == 3 || q == 9) return 2;
      if (q == 5) return 3;
      return 4;
    end
    return (q % 2 == 1) ? 1 : 3;
  endfunction

  function automatic logic [3:0] expVerdict(input int sc);
    if (sc >= 3) return 4'b1010;
    if (sc == 2) return 4'b0110;
    return 4'b1011;
  endfunction

  // Plays one round starting in QUESTION with exp_que known, and checks the
  // following QUESTION entry or the final verdict.
  task automatic playRound(input bit correct);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("round_input_state", STATE, 4'b0100);
    checkOutput("round_input_din", DIN, 4'd0);
    d = pickDin(exp_que, correct);
    repeat (d) applyStimulus(0, 1, 0, 0);
    checkOutput("round_din", DIN, 4'(d));
    applyStimulus(0, 0, 1, 0);
    if (correct) exp_score++;
    checkOutput("round_result", STATE, correct ? 4'b1000 : 4'b0111);
    checkOutput("round_score", SCORE, 8'(exp_score));
    applyStimulus(0, 0, 0, 1);
    next_que = 4'd2 + {1'b0, ref_lfsr[2:0]};
    applyStimulus(0, 0, 0, 1);
    exp_round++;
    if (exp_round < 4) begin
      exp_que = next_que;
      checkOutput("round_next_q", STATE, 4'b0011);
      checkOutput("round_next_que", QUE, exp_que);
    end else begin
      checkOutput("verdict_state", STATE, expVerdict(exp_score));
      checkOutput("verdict_score", SCORE, 8'(exp_score));
    end
  endtask

  task automatic startGame();
    exp_que = 4'd2 + {1'b0, ref_lfsr[2:0]};
    exp_score = 0;
    exp_round = 0;
    applyStimulus(1, 0, 0, 0);
    checkOutput("start_state", STATE, 4'b0011);
    checkOutput("start_que", QUE, exp_que);
    checkOutput("start_score", SCORE, 8'd0);
  endtask

  initial begin
    // Reset values.
    repeat (3) @(negedge CLK);
    checkOutput("reset_state", STATE, 4'b0010);
    checkOutput("reset_que", QUE, 4'd0);
    checkOutput("reset_din", DIN, 4'd0);
    checkOutput("reset_score", SCORE, 8'd0);
    nRST = 1'b1;
    applyStimulus(0, 1, 1, 1);
    checkOutput("ready_ignores_tick", STATE, 4'b0010);

    // Game 1: first question forced to 6, ends in DRAW with 2 correct.
    waitLow3(3'd4);
    startGame();
    checkOutput("q6_que", QUE, 4'd6);
    applyStimulus(0, 1, 0, 0);
    checkOutput("question_ignores_sel", DIN, 4'd0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("question_after_1tick", STATE, 4'b0011);
    applyStimulus(0, 0, 0, 1);
    checkOutput("input_entry_state", STATE, 4'b0100);
    checkOutput("input_entry_din", DIN, 4'd0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 1, 0, 0);
      checkOutput("sel_wrap", DIN, 4'(i % 5));
    end
    applyStimulus(0, 0, 1, 0);
    checkOutput("ok_at_din0_ignored", STATE, 4'b0100);
    repeat (4) applyStimulus(0, 0, 0, 1);
    checkOutput("input_after_4ticks", STATE, 4'b0100);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0);
    exp_score = 1;
    checkOutput("ok_beats_sel_good", STATE, 4'b1000);
    checkOutput("good_score", SCORE, 8'd1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("good_holds", STATE, 4'b1000);
    next_que = 4'd2 + {1'b0, ref_lfsr[2:0]};
    applyStimulus(1, 0, 0, 1);
    exp_round = 1;
    exp_que = next_que;
    checkOutput("good_to_question", STATE, 4'b0011);
    checkOutput("round2_que", QUE, exp_que);
    applyStimulus(0, 1, 0, 0);
    checkOutput("din_holds_outside_input", DIN, 4'd2);

    // Round 2: timeout.
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("round2_input", STATE, 4'b0100);
    applyStimulus(1, 0, 0, 0);
    checkOutput("input_ignores_start", STATE, 4'b0100);
    repeat (4) applyStimulus(0, 0, 0, 1);
    checkOutput("before_timeout", STATE, 4'b0100);
    applyStimulus(0, 0, 0, 1);
    checkOutput("timeout_ouch", STATE, 4'b1001);
    checkOutput("ouch_score", SCORE, 8'd1);
    applyStimulus(0, 0, 0, 1);
    next_que = 4'd2 + {1'b0, ref_lfsr[2:0]};
    applyStimulus(0, 0, 0, 1);
    exp_round = 2;
    exp_que = next_que;
    checkOutput("ouch_to_question", STATE, 4'b0011);
    checkOutput("round3_que", QUE, exp_que);

    // Round 3: correct answer together with the 5th tick.
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    d = pickDin(exp_que, 1'b1);
    repeat (d) applyStimulus(0, 1, 0, 0);
    repeat (4) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1);
    exp_score = 2;
    checkOutput("ok_beats_timeout", STATE, 4'b1000);
    checkOutput("round3_score", SCORE, 8'd2);
    applyStimulus(0, 0, 0, 1);
    next_que = 4'd2 + {1'b0, ref_lfsr[2:0]};
    applyStimulus(0, 0, 0, 1);
    exp_round = 3;
    exp_que = next_que;
    checkOutput("round4_que", QUE, exp_que);

    // Round 4 wrong -> DRAW.
    playRound(1'b0);
    checkOutput("draw_state", STATE, 4'b0110);
    applyStimulus(0, 0, 0, 1);
    checkOutput("draw_ignores_tick", STATE, 4'b0110);
    applyStimulus(1, 0, 0, 0);
    checkOutput("draw_start_ready", STATE, 4'b0010);
    checkOutput("score_held_in_ready", SCORE, 8'd2);

    // Game 2: first question forced to 9, all wrong -> LOSE.
    waitLow3(3'd7);
    startGame();
    checkOutput("q9_que", QUE, 4'd9);
    repeat (4) playRound(1'b0);
    checkOutput("lose_state", STATE, 4'b1011);
    applyStimulus(1, 0, 0, 0);
    checkOutput("lose_start_ready", STATE, 4'b0010);

    // Game 3: all correct -> WIN.
    startGame();
    repeat (4) playRound(1'b1);
    checkOutput("win_state", STATE, 4'b1010);
    checkOutput("win_score", SCORE, 8'd4);
    applyStimulus(1, 0, 0, 0);
    checkOutput("win_start_ready", STATE, 4'b0010);

    // Game 4: reset in INPUT after a scored round.
    startGame();
    playRound(1'b1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("pre_reset_input", STATE, 4'b0100);
    nRST = 1'b0;
    applyStimulus(0, 0, 0, 0);
    checkOutput("midgame_reset_state", STATE, 4'b0010);
    checkOutput("midgame_reset_score", SCORE, 8'd0);
    checkOutput("midgame_reset_que", QUE, 4'd0);
    checkOutput("midgame_reset_din", DIN, 4'd0);
    nRST = 1'b1;
    // LFSR seed is 0x01 right after reset, so the first question is 3.
    applyStimulus(1, 0, 0, 0);
    checkOutput("seed_que", QUE, 4'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
